// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared mode and direction definitions for the LED pattern generator
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_GRAY    = 2'd3
  } mode_t;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - free-running divider producing a one-cycle step strobe every TICK_DIV cycles
module led_prescaler #(
  parameter int TICK_DIV = 900000
) (
  input  logic clk,
  input  logic rst,
  output logic stp
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] pcnt;

  assign stp = (pcnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (stp) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - runtime-selectable LED patterns (count, scan, breathe, gray) stepped by a prescaler
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LEDS   = 5,
  parameter int TICK_DIV = 900000,
  parameter int PWM_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              mode_stb,
  output logic [N_LEDS-1:0] led,
  output logic              tick
);

  localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [PW-1:0]       POS_MAX  = PW'(N_LEDS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic stp;

  mode_t               cur_mode, cur_mode_n;
  mode_t               pend, pend_n;
  logic                pend_v, pend_v_n;
  logic [N_LEDS-1:0]   step, step_n;
  logic [PW-1:0]       pos, pos_n;
  logic                dir, dir_n;
  logic [PWM_BITS-1:0] duty, duty_n;
  logic [PWM_BITS-1:0] pwm;
  logic [N_LEDS-1:0]   led_n;

  led_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk(clk),
    .rst(rst),
    .stp(stp)
  );

  always_comb begin
    cur_mode_n = cur_mode;
    pend_n     = pend;
    pend_v_n   = pend_v;
    step_n     = step;
    pos_n      = pos;
    dir_n      = dir;
    duty_n     = duty;
    led_n      = '0;

    // A strobe coinciding with a step is held for the following step.
    if (mode_stb) begin
      pend_n   = mode_t'(mode);
      pend_v_n = 1'b1;
    end else if (stp) begin
      pend_v_n = 1'b0;
    end

    if (stp) begin
      if (pend_v) begin
        cur_mode_n = pend;
        step_n     = '0;
        pos_n      = '0;
        dir_n      = UP;
        duty_n     = '0;
      end else begin
        case (cur_mode)
          MODE_COUNT, MODE_GRAY: begin
            step_n = step + N_LEDS'(1);
          end
          MODE_SCAN: begin
            if (POS_MAX != '0) begin
              if (dir == UP) begin
                pos_n = pos + PW'(1);
                if (pos_n == POS_MAX) dir_n = DOWN;
              end else begin
                pos_n = pos - PW'(1);
                if (pos_n == '0) dir_n = UP;
              end
            end
          end
          MODE_BREATHE: begin
            if (dir == UP) begin
              duty_n = duty + PWM_BITS'(1);
              if (duty_n == DUTY_MAX) dir_n = DOWN;
            end else begin
              duty_n = duty - PWM_BITS'(1);
              if (duty_n == '0) dir_n = UP;
            end
          end
          default: ;
        endcase
      end
    end

    case (cur_mode_n)
      MODE_COUNT:   led_n = step_n;
      MODE_SCAN:    led_n = N_LEDS'(1) << pos_n;
      MODE_BREATHE: led_n = {N_LEDS{pwm < duty_n}};
      MODE_GRAY:    led_n = step_n ^ (step_n >> 1);
      default:      led_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_mode <= MODE_COUNT;
      pend     <= MODE_COUNT;
      pend_v   <= 1'b0;
      step     <= '0;
      pos      <= '0;
      dir      <= UP;
      duty     <= '0;
      pwm      <= '0;
      led      <= '0;
      tick     <= 1'b0;
    end else begin
      cur_mode <= cur_mode_n;
      pend     <= pend_n;
      pend_v   <= pend_v_n;
      step     <= step_n;
      pos      <= pos_n;
      dir      <= dir_n;
      duty     <= duty_n;
      pwm      <= pwm + PWM_BITS'(1);
      led      <= led_n;
      tick     <= stp;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen against a step-index reference model
module tb_led_pattern_gen;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       mode_stb;
  logic [4:0] led;
  logic       tick;

  int total = 0;
  int bad   = 0;

  // Reference model: edge index since reset, mode bookkeeping and steps since the last clear.
  int mc, mcur, mpend, mpendv, mk;
  logic [4:0] exp_led;
  logic       exp_tick;

  led_pattern_gen #(.N_LEDS(5), .TICK_DIV(4), .PWM_BITS(2)) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .mode_stb(mode_stb),
    .led(led),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tri_w(int k, int mx);
    int t;
    if (mx == 0) return 0;
    t = k % (2 * mx);
    return (t <= mx) ? t : 2 * mx - t;
  endfunction

  function automatic logic [4:0] pat(int m, int k, int c);
    int g;
    case (m)
      0: return 5'(k % 32);
      1: return 5'(1 << tri_w(k, 4));
      2: return ((c % 4) < tri_w(k, 3)) ? 5'h1f : 5'h00;
      default: begin
        g = k % 32;
        return 5'(g ^ (g >> 1));
      end
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit s, input int m);
    bit stp;
    if (r) begin
      mc = 0; mcur = 0; mpend = 0; mpendv = 0; mk = 0;
      exp_led = '0; exp_tick = 1'b0;
    end else begin
      stp = (mc % 4 == 3);
      if (stp) begin
        if (mpendv != 0) begin
          mcur = mpend;
          mk = 0;
        end else begin
          mk++;
        end
      end
      if (s) begin
        mpend = m;
        mpendv = 1;
      end else if (stp) begin
        mpendv = 0;
      end
      exp_tick = stp;
      exp_led = pat(mcur, mk, mc);
      mc++;
    end
  endtask

  task automatic cyc(input bit r, input bit s, input logic [1:0] m);
    rst = r;
    mode_stb = s;
    mode = m;
    @(posedge clk);
    model_edge(r, s, int'(m));
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 2'd0);
      total++;
      if (led !== 5'd0 || tick !== 1'b0) begin
        bad++;
        $display("FAIL reset led=%b tick=%b want led=00000 tick=0", led, tick);
      end
    end
  endtask

  task automatic test_count;
    int nt = 0;
    for (int i = 0; i < 33 * 4 + 2; i++) begin
      cyc(1'b0, 1'b0, 2'd0);
      total++;
      if (led !== exp_led || tick !== exp_tick) begin
        bad++;
        $display("FAIL count_cyc c=%0d led=%b want %b tick=%b want %b", mc, led, exp_led, tick, exp_tick);
      end
      if (tick === 1'b1) begin
        nt++;
        if (nt <= 3 || nt == 32) begin
          total++;
          if (led !== 5'(nt % 32)) begin
            bad++;
            $display("FAIL count_tick n=%0d led=%b want %b", nt, led, 5'(nt % 32));
          end
        end
      end
    end
  endtask

  task automatic test_scan;
    int nt = 0;
    cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 4 * 12; i++) begin
      cyc(1'b0, 1'b0, 2'd0);
      total++;
      if (led !== exp_led || tick !== exp_tick) begin
        bad++;
        $display("FAIL scan_cyc c=%0d led=%b want %b tick=%b want %b", mc, led, exp_led, tick, exp_tick);
      end
      if (tick === 1'b1) begin
        nt++;
        if (nt == 1) begin
          total++;
          if (led !== 5'b00001) begin
            bad++;
            $display("FAIL scan_first led=%b want 00001", led);
          end
        end
      end
    end
  endtask

  task automatic test_breathe;
    int j = 0;
    int highs = 0;
    bit have_win = 0;
    cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 4 * 11; i++) begin
      cyc(1'b0, 1'b0, 2'd0);
      total++;
      if (led !== exp_led || tick !== exp_tick) begin
        bad++;
        $display("FAIL breathe_cyc c=%0d led=%b want %b tick=%b want %b", mc, led, exp_led, tick, exp_tick);
      end
      if (tick === 1'b1) begin
        if (have_win) begin
          total++;
          if (highs != tri_w(j - 1, 3)) begin
            bad++;
            $display("FAIL breathe_duty step=%0d on_cycles=%0d want %0d", j - 1, highs, tri_w(j - 1, 3));
          end
        end
        have_win = 1;
        highs = 0;
        j++;
      end
      if (have_win && led[0] === 1'b1) highs++;
    end
  endtask

  task automatic test_gray;
    int nt = 0;
    logic [4:0] prev;
    cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 2'd3);
    prev = led;
    for (int i = 0; i < 4 * 34; i++) begin
      cyc(1'b0, 1'b0, 2'd0);
      total++;
      if (led !== exp_led || tick !== exp_tick) begin
        bad++;
        $display("FAIL gray_cyc c=%0d led=%b want %b tick=%b want %b", mc, led, exp_led, tick, exp_tick);
      end
      if (tick === 1'b1) begin
        nt++;
        if (nt > 1) begin
          total++;
          if ($countones(led ^ prev) != 1) begin
            bad++;
            $display("FAIL gray_onebit prev=%b led=%b want one bit changed", prev, led);
          end
        end
        prev = led;
      end
    end
  endtask

  task automatic test_strobe_edges;
    // Strobe coincident with the step edge: still counting after it, scan one step later.
    cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 2'd1);
    total++;
    if (led !== 5'd1 || tick !== 1'b1) begin
      bad++;
      $display("FAIL coincident_first led=%b tick=%b want led=00001(count) tick=1", led, tick);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 2'd0);
    total++;
    if (led !== 5'b00001 || tick !== 1'b1) begin
      bad++;
      $display("FAIL coincident_next led=%b tick=%b want led=00001(scan) tick=1", led, tick);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 2'd0);
    total++;
    if (led !== 5'b00010) begin
      bad++;
      $display("FAIL coincident_scan led=%b want 00010", led);
    end

    // Two strobes in one period: the later one (gray) wins.
    cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 2'd1);
    cyc(1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 2'd0);
    total++;
    if (led !== 5'b00011 || tick !== 1'b1) begin
      bad++;
      $display("FAIL last_strobe led=%b tick=%b want led=00011 tick=1", led, tick);
    end

    // Reset mid-scan discards the scan mode.
    cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 2'd0);
    total++;
    if (led !== 5'd0 || tick !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset led=%b tick=%b want led=00000 tick=0", led, tick);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 2'd0);
    total++;
    if (led !== 5'd1 || tick !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_count led=%b tick=%b want led=00001 tick=1", led, tick);
    end
  endtask

  task automatic test_random;
    bit r, s;
    logic [1:0] m;
    cyc(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 5) == 0);
      m = 2'($urandom_range(0, 3));
      cyc(r, s, m);
      total++;
      if (led !== exp_led || tick !== exp_tick) begin
        bad++;
        $display("FAIL random_cyc i=%0d c=%0d led=%b want %b tick=%b want %b", i, mc, led, exp_led, tick, exp_tick);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    mode = 2'd0;
    mode_stb = 1'b0;
    test_reset();
    test_count();
    test_scan();
    test_breathe();
    test_gray();
    test_strobe_edges();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
